mem_wb_pipe: RTL and testbench

//  Clocked MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer, flush and
//  WB result select. Sits between the data-memory stage and register-file writeback. Lets WB stall
//  (e.g. regfile port conflict) without a combinational ready path back into MEM.

---
 rtl/mem_wb_pipe_pkg.sv | 13 +
 rtl/mem_wb_pipe_skid_buf.sv | 57 +++++
 rtl/mem_wb_pipe.sv | 88 ++++++++
 tb/tb_mem_wb_pipe.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// mem_wb_pipe_pkg: shared state encoding and sizing helpers for the MEM->WB pipeline register
package mem_wb_pipe_pkg;
  typedef enum logic [1:0] {
    MWB_EMPTY = 2'd0,
    MWB_FULL  = 2'd1,
    MWB_SKID  = 2'd2
  } mwb_state_e;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  function automatic int entry_w(input int dw, input int aw);
    return 2 + aw + 2 * dw;
  endfunction
endpackage

// File: rtl/mem_wb_pipe_skid_buf.sv
// mem_wb_pipe_skid_buf: generic 2-entry valid/ready skid buffer with registered in_ready
module mem_wb_pipe_skid_buf
  import mem_wb_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         skid_valid,
  output logic [W-1:0] skid_data
);
  mwb_state_e state, state_nxt;
  logic [W-1:0] head_q, skid_q;
  logic in_fire, out_fire;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MWB_EMPTY;
    else      state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      MWB_EMPTY: state_nxt = in_fire ? MWB_FULL : MWB_EMPTY;
      MWB_FULL:  state_nxt = (in_fire & ~out_fire) ? MWB_SKID :
                             (out_fire & ~in_fire) ? MWB_EMPTY : MWB_FULL;
      MWB_SKID:  state_nxt = out_fire ? MWB_FULL : MWB_SKID;
      default:   state_nxt = MWB_EMPTY;
    endcase
    if (flush) state_nxt = MWB_EMPTY;
  end
  always_comb begin
    in_ready   = state != MWB_SKID;
    out_valid  = state != MWB_EMPTY;
    skid_valid = state == MWB_SKID;
  end
  // Head is reloaded from input when empty or draining same cycle; skid only fills on a stalled accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if (in_fire & (state == MWB_EMPTY | out_fire)) head_q <= in_data;
      else if (out_fire & state == MWB_SKID)         head_q <= skid_q;
      if (in_fire & ~out_fire & state == MWB_FULL)   skid_q <= in_data;
    end
  end
  assign out_data  = head_q;
  assign skid_data = skid_q;
endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB pipeline register with skid buffer, flush, result select and forwarding taps
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic              m_write_reg,
  input  logic              m_mem_to_reg,
  input  logic [DATA_W-1:0] data_from_mem,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] reg_des,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_write_reg,
  output logic              w_mem_to_reg,
  output logic [DATA_W-1:0] data_from_mem_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [ADDR_W-1:0] reg_des_o,
  output logic [DATA_W-1:0] w_result,
  output logic              fwd0_en,
  output logic [ADDR_W-1:0] fwd0_reg,
  output logic [DATA_W-1:0] fwd0_data,
  output logic              fwd1_en,
  output logic [ADDR_W-1:0] fwd1_reg,
  output logic [DATA_W-1:0] fwd1_data
);
  localparam int W = entry_w(DATA_W, ADDR_W);
  logic [W-1:0] in_word, head, skid;
  logic skid_valid;
  // x0 is never a real destination, so its write enable is dropped at capture.
  assign in_word = {m_write_reg & (reg_des != '0), m_mem_to_reg, reg_des, data_from_mem, alu_result};
  generate
    if (SKID) begin : g_skid
      mem_wb_pipe_skid_buf #(.W(W)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (m_valid),
        .in_ready   (m_ready),
        .in_data    (in_word),
        .out_valid  (w_valid),
        .out_ready  (w_ready),
        .out_data   (head),
        .skid_valid (skid_valid),
        .skid_data  (skid)
      );
    end else begin : g_single
      logic v;
      logic [W-1:0] e;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v <= 1'b0;
          e <= '0;
        end else if (flush) begin
          v <= 1'b0;
        end else if (m_valid & m_ready) begin
          v <= 1'b1;
          e <= in_word;
        end else if (w_ready) begin
          v <= 1'b0;
        end
      end
      assign m_ready    = ~v | w_ready;
      assign w_valid    = v;
      assign head       = e;
      assign skid_valid = 1'b0;
      assign skid       = '0;
    end
  endgenerate
  logic head_wr, skid_wr, skid_m2r;
  logic [DATA_W-1:0] skid_dfm, skid_alu;
  assign {head_wr, w_mem_to_reg, reg_des_o, data_from_mem_o, alu_result_o} = head;
  assign {skid_wr, skid_m2r, fwd1_reg, skid_dfm, skid_alu} = skid;
  assign w_result    = w_mem_to_reg ? data_from_mem_o : alu_result_o;
  assign w_write_reg = head_wr & w_valid;
  assign fwd0_en     = w_write_reg;
  assign fwd0_reg    = reg_des_o;
  assign fwd0_data   = w_result;
  assign fwd1_en     = skid_valid & skid_wr;
  assign fwd1_data   = skid_m2r ? skid_dfm : skid_alu;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: randomized and directed checks of both skid builds against a queue model
module tb_mem_wb_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  typedef struct packed {
    logic wr;
    logic m2r;
    logic [AW-1:0] rd;
    logic [DW-1:0] dfm;
    logic [DW-1:0] alu;
  } ent_t;
  logic clk = 0, rst = 0, flush = 0, m_valid = 0, m_write_reg = 0, m_mem_to_reg = 0, w_ready = 0;
  logic [DW-1:0] data_from_mem = 0, alu_result = 0;
  logic [AW-1:0] reg_des = 0;
  logic a_m_ready, a_w_valid, a_w_write_reg, a_w_m2r, a_fwd0_en, a_fwd1_en;
  logic [DW-1:0] a_dfm, a_alu, a_res, a_fwd0_data, a_fwd1_data;
  logic [AW-1:0] a_rd, a_fwd0_reg, a_fwd1_reg;
  logic b_m_ready, b_w_valid, b_w_write_reg, b_w_m2r, b_fwd0_en, b_fwd1_en;
  logic [DW-1:0] b_dfm, b_alu, b_res, b_fwd0_data, b_fwd1_data;
  logic [AW-1:0] b_rd, b_fwd0_reg, b_fwd1_reg;
  ent_t qa[$], qb[$];
  ent_t la = '0, lb = '0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .m_valid(m_valid), .m_ready(a_m_ready),
    .m_write_reg(m_write_reg), .m_mem_to_reg(m_mem_to_reg), .data_from_mem(data_from_mem),
    .alu_result(alu_result), .reg_des(reg_des), .w_valid(a_w_valid), .w_ready(w_ready),
    .w_write_reg(a_w_write_reg), .w_mem_to_reg(a_w_m2r), .data_from_mem_o(a_dfm),
    .alu_result_o(a_alu), .reg_des_o(a_rd), .w_result(a_res), .fwd0_en(a_fwd0_en),
    .fwd0_reg(a_fwd0_reg), .fwd0_data(a_fwd0_data), .fwd1_en(a_fwd1_en),
    .fwd1_reg(a_fwd1_reg), .fwd1_data(a_fwd1_data));
  mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .m_valid(m_valid), .m_ready(b_m_ready),
    .m_write_reg(m_write_reg), .m_mem_to_reg(m_mem_to_reg), .data_from_mem(data_from_mem),
    .alu_result(alu_result), .reg_des(reg_des), .w_valid(b_w_valid), .w_ready(w_ready),
    .w_write_reg(b_w_write_reg), .w_mem_to_reg(b_w_m2r), .data_from_mem_o(b_dfm),
    .alu_result_o(b_alu), .reg_des_o(b_rd), .w_result(b_res), .fwd0_en(b_fwd0_en),
    .fwd0_reg(b_fwd0_reg), .fwd0_data(b_fwd0_data), .fwd1_en(b_fwd1_en),
    .fwd1_reg(b_fwd1_reg), .fwd1_data(b_fwd1_data));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] res(input ent_t e);
    return e.m2r ? e.dfm : e.alu;
  endfunction
  task automatic check_outs();
    check("a_w_valid", a_w_valid, qa.size() > 0);
    check("a_m_ready", a_m_ready, qa.size() < 2);
    check("a_w_write_reg", a_w_write_reg, qa.size() > 0 && la.wr);
    check("a_fwd0_en", a_fwd0_en, qa.size() > 0 && la.wr);
    check("a_head", {a_w_m2r, a_rd, a_dfm, a_alu}, {la.m2r, la.rd, la.dfm, la.alu});
    check("a_w_result", a_res, res(la));
    check("a_fwd0", {a_fwd0_reg, a_fwd0_data}, {la.rd, res(la)});
    check("a_fwd1_en", a_fwd1_en, qa.size() > 1 && qa[qa.size()-1].wr);
    if (qa.size() > 1) check("a_fwd1", {a_fwd1_reg, a_fwd1_data}, {qa[1].rd, res(qa[1])});
    check("b_w_valid", b_w_valid, qb.size() > 0);
    check("b_m_ready", b_m_ready, qb.size() == 0 || w_ready);
    check("b_w_write_reg", b_w_write_reg, qb.size() > 0 && lb.wr);
    check("b_head", {b_w_m2r, b_rd, b_dfm, b_alu}, {lb.m2r, lb.rd, lb.dfm, lb.alu});
    check("b_w_result", b_res, res(lb));
    check("b_fwd1_en", b_fwd1_en, 1'b0);
  endtask
  // Called at a negedge: drive, check current outputs, then advance the model across the posedge.
  task automatic cycle(input logic mv, input logic wr, input logic m2r, input logic [AW-1:0] rd,
                       input logic [DW-1:0] d, input logic [DW-1:0] a, input logic wrdy, input logic fl);
    ent_t e;
    logic ia, oa, ib, ob;
    m_valid = mv; m_write_reg = wr; m_mem_to_reg = m2r; reg_des = rd;
    data_from_mem = d; alu_result = a; w_ready = wrdy; flush = fl;
    #1;
    check_outs();
    e = '{wr: wr && rd != 0, m2r: m2r, rd: rd, dfm: d, alu: a};
    ia = mv && qa.size() < 2;
    oa = qa.size() > 0 && wrdy;
    ib = mv && (qb.size() == 0 || wrdy);
    ob = qb.size() > 0 && wrdy;
    @(posedge clk);
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (oa) void'(qa.pop_front());
      if (ia) qa.push_back(e);
      if (ob) void'(qb.pop_front());
      if (ib) qb.push_back(e);
    end
    if (qa.size() > 0) la = qa[0];
    if (qb.size() > 0) lb = qb[0];
    @(negedge clk);
  endtask
  task automatic idle(input logic wrdy);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, wrdy, 1'b0);
  endtask
  initial begin
    m_valid = 1;
    m_write_reg = 1;
    reg_des = 5'd3;
    repeat (3) @(negedge clk);
    #1;
    check("rst_w_valid", a_w_valid, 1'b0);
    check("rst_m_ready", a_m_ready, 1'b1);
    check("rst_w_write_reg", a_w_write_reg, 1'b0);
    check("rst_b_w_valid", b_w_valid, 1'b0);
    @(negedge clk);
    rst = 1;
    // Streaming
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, i % 2 == 0, AW'(i + 1), 32'h100 + i, i, 1'b1, 1'b0);
      check("stream_res", a_res, (i % 2 == 0) ? 32'h100 + i : i);
      check("stream_valid", a_w_valid, 1'b1);
    end
    idle(1'b1);
    idle(1'b1);
    // Backpressure: A, B fill, C held off then drained in order
    cycle(1'b1, 1'b1, 1'b0, 5'd1, 32'h0, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 5'd2, 32'h0, 32'hB, 1'b0, 1'b0);
    check("bp_m_ready", a_m_ready, 1'b0);
    check("bp_fwd1_en", a_fwd1_en, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'hC, 1'b0, 1'b0);
    check("bp_head_a", a_res, 32'hA);
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'hC, 1'b1, 1'b0);
    check("bp_head_b", a_res, 32'hB);
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 32'hC, 1'b1, 1'b0);
    check("bp_head_c", a_res, 32'hC);
    idle(1'b1);
    idle(1'b1);
    // Flush in SKID state with D offered
    cycle(1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 32'hE1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 5'd6, 32'h0, 32'hE2, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 5'd7, 32'h0, 32'hD, 1'b0, 1'b1);
    check("fl_w_valid", a_w_valid, 1'b0);
    check("fl_m_ready", a_m_ready, 1'b1);
    check("fl_fwd", {a_fwd0_en, a_fwd1_en}, 2'b00);
    idle(1'b1);
    idle(1'b1);
    // x0 gating
    cycle(1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h55, 1'b0, 1'b0);
    check("x0_w_write_reg", a_w_write_reg, 1'b0);
    check("x0_fwd0_en", a_fwd0_en, 1'b0);
    check("single_stall_m_ready", b_m_ready, 1'b0);
    idle(1'b1);
    cycle(1'b1, 1'b1, 1'b0, 5'd5, 32'h0, 32'h66, 1'b0, 1'b0);
    check("x5_w_write_reg", a_w_write_reg, 1'b1);
    check("x5_fwd0_reg", a_fwd0_reg, 5'd5);
    idle(1'b1);
    // Reset mid-stall
    cycle(1'b1, 1'b1, 1'b1, 5'd9, 32'h77, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 5'd10, 32'h88, 32'h0, 1'b0, 1'b0);
    m_valid = 0;
    #2 rst = 0;
    #1;
    check("mr_w_valid", a_w_valid, 1'b0);
    check("mr_outs", {a_w_write_reg, a_fwd0_en, a_fwd1_en, a_rd, a_res}, '0);
    check("mr_b_w_valid", b_w_valid, 1'b0);
    qa.delete();
    qb.delete();
    la = '0;
    lb = '0;
    @(negedge clk);
    rst = 1;
    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 31)), $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
            $urandom_range(0, 19) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
